// File: rtl/inst_fifo.sv
// rtl/inst_fifo.sv - dual-slot instruction FIFO between fetch and decode
// Optional feature: define INST_FIFO_ADEL_EN to carry a per-entry fetch address-error flag.
module inst_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     in_en0,
  input  logic                     in_en1,
  input  logic [31:0]              in_pc0,
  input  logic [31:0]              in_pc1,
  input  logic [31:0]              in_instr0,
  input  logic [31:0]              in_instr1,
`ifdef INST_FIFO_ADEL_EN
  input  logic                     in_adel0,
  input  logic                     in_adel1,
  output logic                     out_adel0,
  output logic                     out_adel1,
`endif
  input  logic [1:0]               out_pop,
  output logic                     out_valid0,
  output logic                     out_valid1,
  output logic [31:0]              out_pc0,
  output logic [31:0]              out_instr0,
  output logic [31:0]              out_pc1,
  output logic [31:0]              out_instr1,
  output logic                     almost_full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_mem_pc    [DEPTH];
  logic [31:0]   r_mem_instr [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [AW-1:0] w_head1;
  logic [AW-1:0] w_tail1;
  logic [CW-1:0] w_free;
  logic [CW-1:0] w_push;
  logic [CW-1:0] w_pop_req;
  logic [CW-1:0] w_pop_eff;
  logic          w_acc0;
  logic          w_acc1;

  // Space is judged on the pre-pop count; slot 1 only rides along behind slot 0.
  assign w_free    = CW'(DEPTH) - r_count;
  assign w_acc0    = in_en0 && (w_free >= CW'(1));
  assign w_acc1    = in_en0 && in_en1 && (w_free >= CW'(2));
  assign w_push    = CW'(w_acc0) + CW'(w_acc1);
  assign w_pop_req = (out_pop == 2'd0) ? CW'(0) : ((out_pop == 2'd1) ? CW'(1) : CW'(2));
  assign w_pop_eff = (w_pop_req > r_count) ? r_count : w_pop_req;
  assign w_tail1   = r_tail + AW'(1);
  assign w_head1   = r_head + AW'(1);

  // Pointer and occupancy update; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + w_pop_eff[AW-1:0];
      r_tail  <= r_tail + w_push[AW-1:0];
      r_count <= r_count + w_push - w_pop_eff;
    end
  end

  // Entry storage, written at tail/tail+1; left unreset since valids mask it.
  always_ff @(posedge clk) begin
    if (w_acc0 && !flush) begin
      r_mem_pc[r_tail]    <= in_pc0;
      r_mem_instr[r_tail] <= in_instr0;
    end
    if (w_acc1 && !flush) begin
      r_mem_pc[w_tail1]    <= in_pc1;
      r_mem_instr[w_tail1] <= in_instr1;
    end
  end

`ifdef INST_FIFO_ADEL_EN
  logic r_mem_adel [DEPTH];
  logic w_adel0;
  logic w_adel1;

  // A misaligned PC always raises the address-error flag.
  assign w_adel0 = in_adel0 | (in_pc0[1:0] != 2'b00);
  assign w_adel1 = in_adel1 | (in_pc1[1:0] != 2'b00);

  // Flag storage follows the same write rules as pc/instr.
  always_ff @(posedge clk) begin
    if (w_acc0 && !flush) r_mem_adel[r_tail]  <= w_adel0;
    if (w_acc1 && !flush) r_mem_adel[w_tail1] <= w_adel1;
  end

  assign out_adel0 = out_valid0 ? r_mem_adel[r_head]  : 1'b0;
  assign out_adel1 = out_valid1 ? r_mem_adel[w_head1] : 1'b0;
`endif

  assign out_valid0  = (r_count >= CW'(1));
  assign out_valid1  = (r_count >= CW'(2));
  assign out_pc0     = out_valid0 ? r_mem_pc[r_head]     : '0;
  assign out_instr0  = out_valid0 ? r_mem_instr[r_head]  : '0;
  assign out_pc1     = out_valid1 ? r_mem_pc[w_head1]    : '0;
  assign out_instr1  = out_valid1 ? r_mem_instr[w_head1] : '0;
  assign almost_full = (r_count > CW'(DEPTH - 2));
  assign empty       = (r_count == '0);
  assign count       = r_count;

endmodule

// File: tb/tb_inst_fifo.sv
// tb/tb_inst_fifo.sv - self-checking bench for inst_fifo
module tb_inst_fifo;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        in_en0, in_en1;
  logic [31:0] in_pc0, in_pc1, in_instr0, in_instr1;
  logic [1:0]  out_pop;
  logic        out_valid0, out_valid1;
  logic [31:0] out_pc0, out_instr0, out_pc1, out_instr1;
  logic        almost_full, empty;
  logic [4:0]  count;
`ifdef INST_FIFO_ADEL_EN
  logic        in_adel0, in_adel1, out_adel0, out_adel1;
`endif

  inst_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_en0(in_en0), .in_en1(in_en1),
    .in_pc0(in_pc0), .in_pc1(in_pc1),
    .in_instr0(in_instr0), .in_instr1(in_instr1),
`ifdef INST_FIFO_ADEL_EN
    .in_adel0(in_adel0), .in_adel1(in_adel1),
    .out_adel0(out_adel0), .out_adel1(out_adel1),
`endif
    .out_pop(out_pop),
    .out_valid0(out_valid0), .out_valid1(out_valid1),
    .out_pc0(out_pc0), .out_instr0(out_instr0),
    .out_pc1(out_pc1), .out_instr1(out_instr1),
    .almost_full(almost_full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
  entry_t mq[$];

  typedef struct {
    logic en0; logic en1; logic fl; logic [1:0] pop;
    logic [31:0] pc0; logic [31:0] pc1; logic [31:0] i0; logic [31:0] i1;
    int ecnt; logic [31:0] epc0; logic [31:0] ei0; logic [31:0] epc1;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e0, input logic e1, input logic fl, input logic [1:0] p,
                       input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic [31:0] i0, input logic [31:0] i1);
    in_en0 = e0; in_en1 = e1; flush = fl; out_pop = p;
    in_pc0 = pc0; in_pc1 = pc1; in_instr0 = i0; in_instr1 = i1;
  endtask

  // Queue-level model: consume up to the requested amount, then append what fits.
  task automatic model_update();
    int n;
    int room;
    int p;
    entry_t e;
    n = mq.size();
    room = DEPTH - n;
    if (flush) begin
      mq.delete();
      return;
    end
    p = (out_pop == 2'd3) ? 2 : int'(out_pop);
    if (p > n) p = n;
    for (int k = 0; k < p; k++) void'(mq.pop_front());
    if (in_en0 && room >= 1) begin
      e.pc = in_pc0; e.instr = in_instr0; mq.push_back(e);
    end
    if (in_en0 && in_en1 && room >= 2) begin
      e.pc = in_pc1; e.instr = in_instr1; mq.push_back(e);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic compare_model();
    int n;
    n = mq.size();
    chk("count", count, n);
    chk("empty", empty, n == 0);
    chk("almost_full", almost_full, n > DEPTH - 2);
    chk("valid0", out_valid0, n >= 1);
    chk("valid1", out_valid1, n >= 2);
    if (n >= 1) begin
      chk("pc0", out_pc0, mq[0].pc);
      chk("instr0", out_instr0, mq[0].instr);
    end
    if (n >= 2) begin
      chk("pc1", out_pc1, mq[1].pc);
      chk("instr1", out_instr1, mq[1].instr);
    end
  endtask

  initial begin
    logic [31:0] exp_pc;
    vt[0] = '{1'b1, 1'b1, 1'b0, 2'd0, 32'hBFC00000, 32'hBFC00004, 32'h24010001, 32'h24020002, 2, 32'hBFC00000, 32'h24010001, 32'hBFC00004};
    vt[1] = '{1'b0, 1'b0, 1'b0, 2'd1, 32'h0, 32'h0, 32'h0, 32'h0, 1, 32'hBFC00004, 32'h24020002, 32'h0};
    vt[2] = '{1'b1, 1'b1, 1'b0, 2'd3, 32'hA0, 32'hA4, 32'h11, 32'h12, 2, 32'hA0, 32'h11, 32'hA4};
    vt[3] = '{1'b0, 1'b1, 1'b0, 2'd0, 32'hB0, 32'hB4, 32'h21, 32'h22, 2, 32'hA0, 32'h11, 32'hA4};
    vt[4] = '{1'b1, 1'b1, 1'b0, 2'd0, 32'hC0, 32'hC4, 32'h31, 32'h32, 4, 32'hA0, 32'h11, 32'hA4};
    vt[5] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'hD0, 32'hD4, 32'h41, 32'h42, 5, 32'hA0, 32'h11, 32'hA4};
    vt[6] = '{1'b1, 1'b1, 1'b1, 2'd1, 32'hE0, 32'hE4, 32'h51, 32'h52, 0, 32'h0, 32'h0, 32'h0};
    vt[7] = '{1'b1, 1'b1, 1'b0, 2'd0, 32'hF0, 32'hF4, 32'h61, 32'h62, 2, 32'hF0, 32'h61, 32'hF4};

`ifdef INST_FIFO_ADEL_EN
    in_adel0 = 1'b0; in_adel1 = 1'b0;
`endif
    resetn = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'd0, '0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_v0", out_valid0, 0);
    chk("rst_v1", out_valid1, 0);
    resetn = 1'b1;

    // Directed table: push pair, pop, pop-over-count, ignored slot 1, flush priority.
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].en0, vt[i].en1, vt[i].fl, vt[i].pop, vt[i].pc0, vt[i].pc1, vt[i].i0, vt[i].i1);
      cycle();
      chk($sformatf("vec%0d_count", i), count, vt[i].ecnt);
      chk($sformatf("vec%0d_empty", i), empty, vt[i].ecnt == 0);
      chk($sformatf("vec%0d_v0", i), out_valid0, vt[i].ecnt >= 1);
      chk($sformatf("vec%0d_v1", i), out_valid1, vt[i].ecnt >= 2);
      if (vt[i].ecnt >= 1) begin
        chk($sformatf("vec%0d_pc0", i), out_pc0, vt[i].epc0);
        chk($sformatf("vec%0d_instr0", i), out_instr0, vt[i].ei0);
      end
      if (vt[i].ecnt >= 2) chk($sformatf("vec%0d_pc1", i), out_pc1, vt[i].epc1);
    end

    // Fill to capacity, then overflow.
    drive(1'b0, 1'b0, 1'b1, 2'd0, '0, '0, '0, '0);
    cycle();
    for (int c = 0; c < 9; c++) begin
      drive(1'b1, 1'b1, 1'b0, 2'd0, 32'h1000 + 32'(8 * c), 32'h1004 + 32'(8 * c), 32'(c), 32'(c + 100));
      cycle();
      compare_model();
      if (c == 6) begin
        chk("fill7_count", count, 14);
        chk("fill7_af", almost_full, 0);
      end
      if (c >= 7) begin
        chk("fill_full_count", count, 16);
        chk("fill_full_af", almost_full, 1);
      end
    end

    // Shift the pointers so the drain crosses the wrap point.
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b0, 1'b0, 2'd2, '0, '0, '0, '0);
      cycle();
      compare_model();
    end
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b1, 1'b0, 2'd0, 32'h1040 + 32'(8 * c), 32'h1044 + 32'(8 * c), '0, '0);
      cycle();
      compare_model();
    end
    exp_pc = 32'h1010;
    for (int c = 0; c < 8; c++) begin
      chk("drain_pc0", out_pc0, exp_pc);
      chk("drain_pc1", out_pc1, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd8;
      drive(1'b0, 1'b0, 1'b0, 2'd2, '0, '0, '0, '0);
      cycle();
    end
    chk("drain_empty", empty, 1);

    // Randomized traffic against the queue model, with an async reset midway.
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0,
            2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom);
      cycle();
      compare_model();
      if (c == 1500) begin
        resetn = 1'b0;
        #2;
        chk("async_rst_count", count, 0);
        chk("async_rst_empty", empty, 1);
        chk("async_rst_v0", out_valid0, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        mq.delete();
      end
    end

`ifdef INST_FIFO_ADEL_EN
    drive(1'b0, 1'b0, 1'b1, 2'd0, '0, '0, '0, '0);
    cycle();
    in_adel0 = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h80000002, '0, 32'h1, '0);
    cycle();
    chk("adel_misaligned", out_adel0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fifo.md
INST_FIFO -- requirements
Module: inst_fifo

Interface
REQ-001 The module SHALL have parameter DEPTH, default 16, meaning number of entries (power of two, >= 4).
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port resetn, input, 1 bit, the reset; reset SHALL be asynchronous and active-low.
REQ-004 The module SHALL have port flush, input, 1 bit, which discards all stored entries.
REQ-005 The module SHALL have ports in_en0 and in_en1, input, 1 bit each; each is the push request for fetch slot 0 or slot 1.
REQ-006 The module SHALL have ports in_pc0 and in_pc1, input, 32 bits each, the PC of the corresponding fetch slot.
REQ-007 The module SHALL have ports in_instr0 and in_instr1, input, 32 bits each, the instruction word of the corresponding fetch slot.
REQ-008 The module SHALL have port out_pop, input, 2 bits, the number of entries the decode stage consumes this cycle (0, 1 or 2; 3 treated as 2).
REQ-009 The module SHALL have ports out_valid0 and out_valid1, output, 1 bit each, indicating that the head entry or head+1 entry is present.
REQ-010 The module SHALL have ports out_pc0/out_instr0 and out_pc1/out_instr1, output, 32 bits each, carrying the head entry and the head+1 entry.
REQ-011 The module SHALL have port almost_full, output, 1 bit, asserted when fewer than 2 free entries remain.
REQ-012 The module SHALL have port empty, output, 1 bit, asserted when the count is 0.
REQ-013 The module SHALL have port count, output, log2(DEPTH)+1 bits, the number of stored entries.

Function
REQ-014 The module SHALL store entries as {pc, instr} in a circular buffer addressed by head and tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
REQ-015 in_en1 SHALL be honoured only when in_en0=1; if in_en1=1 and in_en0=0, slot 1 SHALL be ignored.
REQ-016 Slot 0 SHALL be written at tail and slot 1 at tail+1; tail SHALL advance by the number of accepted pushes.
REQ-017 Free space SHALL be computed from the pre-pop count; a slot SHALL be accepted only if space remains for it in that order, and excess slots SHALL be silently dropped.
REQ-018 The effective pop SHALL be min(out_pop, count); head SHALL advance by the effective pop.
REQ-019 Simultaneous push and pop SHALL update count = count + pushes_accepted - pops_effective in one cycle.
REQ-020 Outputs out_* SHALL be combinational reads of the registered head and head+1 entries.
REQ-021 out_valid0 SHALL equal (count >= 1) and out_valid1 SHALL equal (count >= 2); data on an invalid slot is don't-care.
REQ-022 Read latency SHALL be one cycle: an entry pushed in cycle N SHALL be visible at the output in cycle N+1, with no same-cycle bypass.
REQ-023 Output order SHALL equal push order: slot 0 before slot 1 within a cycle, and earlier cycles before later cycles.
REQ-024 flush SHALL take priority over push and pop in the same cycle: head, tail and count SHALL be set to 0, and same-cycle pushes SHALL be discarded.
REQ-025 almost_full SHALL equal (count > DEPTH-2); empty SHALL equal (count == 0); both SHALL be derived from registered count.

Reset
REQ-026 While resetn=0, head, tail and count SHALL be 0; empty SHALL be 1; almost_full, out_valid0 and out_valid1 SHALL be 0.
REQ-027 Entry storage SHALL NOT require reset, and no output SHALL expose unreset storage while the corresponding valid is 0.
REQ-028 Reset asserted mid-operation SHALL discard all entries immediately, independent of clk.

Configuration
REQ-029 The module SHALL support the macro INST_FIFO_ADEL_EN, which compiles in the fetch address-error flag.
REQ-030 When INST_FIFO_ADEL_EN is defined, the module SHALL add inputs in_adel0/in_adel1 and outputs out_adel0/out_adel1 (1 bit each), stored per entry alongside pc and instr under the same push, pop and flush rules.
REQ-031 When INST_FIFO_ADEL_EN is defined, the module SHALL additionally force a slot's flag to 1 whenever in_pcX[1:0] != 0.
REQ-032 When INST_FIFO_ADEL_EN is undefined, these ports and the storage bit SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Reset, then push both slots (pc 0xBFC00000/0xBFC00004, instr 0x24010001/0x24020002) with pop=0 -> next cycle count=2, both valids=1, outputs match in order.
REQ-034 DEPTH=16, push 2 per cycle with pop=0 for 7 cycles -> count=14, almost_full=0; 8th cycle -> count=16, almost_full=1; 9th push pair dropped, count stays 16.
REQ-035 count=1, pop=2 and push 2 in the same cycle -> effective pop 1, next count=2, head entry is the first new pushed entry.
REQ-036 Fill, then drain with pop=2 repeatedly across the pointer wrap -> pc sequence continuous, with no duplicates or gaps.
REQ-037 count=5, flush=1 with push 2 and pop 1 in the same cycle -> next cycle count=0, empty=1, out_valid0=0.
REQ-038 With INST_FIFO_ADEL_EN defined, push pc 0x80000002 with in_adel0=0 -> out_adel0=1 when that entry reaches the head.
